multicycle_executor: RTL



---
 rtl/multicycle_executor_if.sv | 32 +++
 rtl/multicycle_executor.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_executor_if.sv
// Instruction handshake and data-memory bus shared by the multi-cycle executor
// and whatever feeds it; slave is the executor side, master the requester/memory side.
interface multicycle_executor_if #(
   parameter int ADDR_WIDTH = 32
);
   logic                  instr_valid;
   logic                  instr_ready;
   logic [31:0]           instruction;
   logic [31:0]           pc_next;
   logic                  done;
   logic                  illegal;
   logic                  misaligned;
   logic                  mem_req;
   logic                  mem_we;
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic [3:0]            mem_be;
   logic [31:0]           mem_wdata;
   logic                  mem_ack;
   logic [31:0]           mem_rdata;

   modport slave (
      input  instr_valid, instruction, pc_next, mem_ack, mem_rdata,
      output instr_ready, done, illegal, misaligned,
             mem_req, mem_we, mem_addr, mem_be, mem_wdata
   );

   modport master (
      output instr_valid, instruction, pc_next, mem_ack, mem_rdata,
      input  instr_ready, done, illegal, misaligned,
             mem_req, mem_we, mem_addr, mem_be, mem_wdata
   );
endinterface

// File: rtl/multicycle_executor.sv
// Multi-cycle RV32I/RV32E executor: IDLE -> EXEC -> (MEM) -> WB, with its own
// register file and a req/ack data-memory port tolerant of any number of wait states.
module multicycle_executor #(
   parameter  int NUM_REGS   = 32,
   parameter  int ADDR_WIDTH = 32,
   localparam int IDX_W      = $clog2(NUM_REGS)
) (
   input  logic                 clk,
   input  logic                 rst,
   multicycle_executor_if.slave bus,
   input  logic [IDX_W-1:0]     dbg_addr,
   output logic [31:0]          dbg_data
);

   typedef enum logic [1:0] {IDLE, EXEC, MEM, WB} state_t;

   localparam logic [6:0] OPC_LUI   = 7'b0110111;
   localparam logic [6:0] OPC_JAL   = 7'b1101111;
   localparam logic [6:0] OPC_OPIMM = 7'b0010011;
   localparam logic [6:0] OPC_OP    = 7'b0110011;
   localparam logic [6:0] OPC_LOAD  = 7'b0000011;
   localparam logic [6:0] OPC_STORE = 7'b0100011;

   state_t      state, state_next;
   logic [31:0] regs [NUM_REGS];
   logic [31:0] instr_q, pc_q, result_q, addr_q, wdata_q;
   logic [3:0]  be_q;
   logic        illegal_q, misaligned_q;

   logic [6:0]  opcode, f7;
   logic [2:0]  f3;
   logic [4:0]  rd_f, rs1_f, rs2_f;
   logic        is_lui, is_jal, is_opimm, is_op, is_load, is_store, mem_op, writes_rd;
   logic        illegal_c, misaligned_c;
   logic [31:0] rs1_val, rs2_val, imm_i, imm_s, op_b, alu_res, exec_result, eff_addr;
   logic [31:0] wdata_c, lane, load_data;
   logic [3:0]  be_c;
   logic [4:0]  shamt;

   function automatic logic idx_bad(input logic [4:0] idx);
      return 32'(idx) >= 32'(NUM_REGS);
   endfunction

   assign opcode   = instr_q[6:0];
   assign rd_f     = instr_q[11:7];
   assign f3       = instr_q[14:12];
   assign rs1_f    = instr_q[19:15];
   assign rs2_f    = instr_q[24:20];
   assign f7       = instr_q[31:25];
   assign is_lui   = opcode == OPC_LUI;
   assign is_jal   = opcode == OPC_JAL;
   assign is_opimm = opcode == OPC_OPIMM;
   assign is_op    = opcode == OPC_OP;
   assign is_load  = opcode == OPC_LOAD;
   assign is_store = opcode == OPC_STORE;
   assign mem_op   = is_load || is_store;
   assign writes_rd = is_lui || is_jal || is_opimm || is_op || is_load;

   assign rs1_val = regs[rs1_f[IDX_W-1:0]];
   assign rs2_val = regs[rs2_f[IDX_W-1:0]];
   assign imm_i   = {{20{instr_q[31]}}, instr_q[31:20]};
   assign imm_s   = {{20{instr_q[31]}}, instr_q[31:25], instr_q[11:7]};
   assign op_b    = is_op ? rs2_val : imm_i;
   assign shamt   = op_b[4:0];
   assign eff_addr = rs1_val + (is_store ? imm_s : imm_i);

   // Only the register fields an instruction actually uses are range-checked.
   always_comb begin
      illegal_c = 1'b0;
      case (opcode)
         OPC_LUI, OPC_JAL: illegal_c = idx_bad(rd_f);
         OPC_OPIMM: illegal_c = idx_bad(rd_f) || idx_bad(rs1_f)
                              || (f3 == 3'b001 && f7 != 7'b0000000)
                              || (f3 == 3'b101 && f7 != 7'b0000000 && f7 != 7'b0100000);
         OPC_OP: illegal_c = idx_bad(rd_f) || idx_bad(rs1_f) || idx_bad(rs2_f)
                           || !(f7 == 7'b0000000
                                || (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101)));
         OPC_LOAD: illegal_c = idx_bad(rd_f) || idx_bad(rs1_f)
                             || f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111;
         OPC_STORE: illegal_c = idx_bad(rs1_f) || idx_bad(rs2_f) || f3[2] || f3[1:0] == 2'b11;
         default: illegal_c = 1'b1;
      endcase
   end

   always_comb begin
      alu_res = '0;
      case (f3)
         3'b000: alu_res = (is_op && f7[5]) ? rs1_val - op_b : rs1_val + op_b;
         3'b001: alu_res = rs1_val << shamt;
         3'b010: alu_res = {31'b0, $signed(rs1_val) < $signed(op_b)};
         3'b011: alu_res = {31'b0, rs1_val < op_b};
         3'b100: alu_res = rs1_val ^ op_b;
         3'b101: alu_res = f7[5] ? 32'($signed(rs1_val) >>> shamt) : rs1_val >> shamt;
         3'b110: alu_res = rs1_val | op_b;
         default: alu_res = rs1_val & op_b;
      endcase
      exec_result = alu_res;
      if (is_lui) exec_result = {instr_q[31:12], 12'h000};
      else if (is_jal) exec_result = pc_q;
   end

   // f3[1:0] encodes the access size for both loads and stores.
   always_comb begin
      misaligned_c = 1'b0;
      be_c         = 4'b1111;
      wdata_c      = '0;
      case (f3[1:0])
         2'b00: be_c = 4'b0001 << eff_addr[1:0];
         2'b01: begin
            be_c         = 4'b0011 << eff_addr[1:0];
            misaligned_c = eff_addr[0];
         end
         default: misaligned_c = eff_addr[1:0] != 2'b00;
      endcase
      if (is_store) begin
         case (f3[1:0])
            2'b00:   wdata_c = {4{rs2_val[7:0]}};
            2'b01:   wdata_c = {2{rs2_val[15:0]}};
            default: wdata_c = rs2_val;
         endcase
      end
   end

   always_comb begin
      lane      = bus.mem_rdata >> {addr_q[1:0], 3'b000};
      load_data = lane;
      case (f3)
         3'b000:  load_data = {{24{lane[7]}}, lane[7:0]};
         3'b001:  load_data = {{16{lane[15]}}, lane[15:0]};
         3'b100:  load_data = {24'b0, lane[7:0]};
         3'b101:  load_data = {16'b0, lane[15:0]};
         default: load_data = lane;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE: if (bus.instr_valid) state_next = EXEC;
         EXEC: state_next = (mem_op && !illegal_c && !misaligned_c) ? MEM : WB;
         MEM:  if (bus.mem_ack) state_next = WB;
         WB:   state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         instr_q      <= '0;
         pc_q         <= '0;
         result_q     <= '0;
         addr_q       <= '0;
         wdata_q      <= '0;
         be_q         <= '0;
         illegal_q    <= 1'b0;
         misaligned_q <= 1'b0;
         for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      end else begin
         case (state)
            IDLE: if (bus.instr_valid) begin
               instr_q      <= bus.instruction;
               pc_q         <= bus.pc_next;
               illegal_q    <= 1'b0;
               misaligned_q <= 1'b0;
            end
            EXEC: begin
               illegal_q    <= illegal_c;
               misaligned_q <= mem_op && !illegal_c && misaligned_c;
               result_q     <= exec_result;
               if (mem_op && !illegal_c) begin
                  addr_q  <= eff_addr;
                  be_q    <= be_c;
                  wdata_q <= wdata_c;
               end
            end
            MEM: if (bus.mem_ack && is_load) result_q <= load_data;
            WB: if (writes_rd && !illegal_q && !misaligned_q && rd_f != 5'd0)
               regs[rd_f[IDX_W-1:0]] <= result_q;
            default: ;
         endcase
      end
   end

   assign bus.instr_ready = (state == IDLE) && !rst;
   assign bus.done        = state == WB;
   assign bus.illegal     = (state == WB) && illegal_q;
   assign bus.misaligned  = (state == WB) && misaligned_q;
   assign bus.mem_req     = state == MEM;
   assign bus.mem_we      = (state == MEM) && is_store;
   assign bus.mem_addr    = addr_q[ADDR_WIDTH-1:0];
   assign bus.mem_be      = be_q;
   assign bus.mem_wdata   = wdata_q;

   assign dbg_data = (dbg_addr == '0 || 32'(dbg_addr) >= 32'(NUM_REGS)) ? 32'h0 : regs[dbg_addr];

endmodule
